// File: rtl/icc_pkg.sv
// rtl/icc_pkg.sv - shared constants, state encoding and flag remap for icc_branch_unit
// Purpose : Bicc condition codes, flag bit positions for the ALU and icc
//           orderings, FSM state type, and the ALU->icc flag remap helper.
// Ports   : none (package)
package icc_pkg;

  // Bicc cond field values
  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  // ALU flag vector ordering {Z,N,C,V}
  localparam int ALU_Z = 3;
  localparam int ALU_N = 2;
  localparam int ALU_C = 1;
  localparam int ALU_V = 0;

  // icc ordering {N,Z,V,C}
  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DSLOT  = 1'b1
  } state_t;

  function automatic logic [3:0] alu_to_icc(input logic [3:0] f);
    return {f[ALU_N], f[ALU_Z], f[ALU_V], f[ALU_C]};
  endfunction

endpackage

// File: rtl/icc_branch_unit_if.sv
// rtl/icc_branch_unit_if.sv - pipeline-side signal bundle for icc_branch_unit
// Purpose : groups the ALU flag capture, branch request and branch result
//           signals. master = EX/decode side, slave = the branch unit.
// Signals : alu_flags, cc_we, stall, br_valid, br_cond, br_annul (to unit)
//           icc, cin, br_taken, annul_ds, dcti_err (from unit)
interface icc_branch_unit_if;
  logic [3:0] alu_flags;
  logic       cc_we;
  logic       stall;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_annul;
  logic [3:0] icc;
  logic       cin;
  logic       br_taken;
  logic       annul_ds;
  logic       dcti_err;

  modport master (
    output alu_flags, cc_we, stall, br_valid, br_cond, br_annul,
    input  icc, cin, br_taken, annul_ds, dcti_err
  );

  modport slave (
    input  alu_flags, cc_we, stall, br_valid, br_cond, br_annul,
    output icc, cin, br_taken, annul_ds, dcti_err
  );
endinterface

// File: rtl/icc_cond_eval.sv
// rtl/icc_cond_eval.sv - combinational SPARC Bicc condition evaluator
// Purpose : truth value of a Bicc cond field against a flag set.
// Ports   : i_flags [3:0] flags in icc order {N,Z,V,C}
//           i_cond  [3:0] Bicc cond field
//           o_true        condition holds
module icc_cond_eval
  import icc_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_true
);

  logic w_n, w_z, w_v, w_c;
  logic w_base;

  assign w_n = i_flags[ICC_N];
  assign w_z = i_flags[ICC_Z];
  assign w_v = i_flags[ICC_V];
  assign w_c = i_flags[ICC_C];

  // Lower eight conditions; the upper eight are their complements.
  always_comb begin
    w_base = 1'b0;
    case (i_cond[2:0])
      COND_BN[2:0]:   w_base = 1'b0;
      COND_BE[2:0]:   w_base = w_z;
      COND_BLE[2:0]:  w_base = w_z | (w_n ^ w_v);
      COND_BL[2:0]:   w_base = w_n ^ w_v;
      COND_BLEU[2:0]: w_base = w_c | w_z;
      COND_BCS[2:0]:  w_base = w_c;
      COND_BNEG[2:0]: w_base = w_n;
      COND_BVS[2:0]:  w_base = w_v;
      default:        w_base = 1'b0;
    endcase
  end

  assign o_true = w_base ^ i_cond[3];

endmodule

// File: rtl/icc_branch_unit.sv
// rtl/icc_branch_unit.sv - icc register, Bicc resolver and delay-slot sequencer
// Purpose : captures ALU flags into icc on cc-modifying ops, feeds carry back
//           to the ALU, resolves Bicc conditions and sequences the delay slot
//           (annul and DCTI-couple detection).
// Ports   : clk      rising-edge clock
//           reset_n  synchronous reset, active-low
//           bus      icc_branch_unit_if.slave (flags, branch request, results)
// Params  : FORWARD  1 = same-cycle branch sees incoming ALU flags on cc write
module icc_branch_unit
  import icc_pkg::*;
#(
  parameter bit FORWARD = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  icc_branch_unit_if.slave        bus
);

  state_t     r_state;
  logic [3:0] r_icc;
  logic       r_br_taken;
  logic       r_annul_ds;
  logic       r_dcti_err;

  logic [3:0] w_alu_icc;
  logic [3:0] w_eff_flags;
  logic       w_cond;
  logic       w_annul;

  assign w_alu_icc   = alu_to_icc(bus.alu_flags);
  assign w_eff_flags = (FORWARD && bus.cc_we) ? w_alu_icc : r_icc;

  icc_cond_eval u_cond_eval (
    .i_flags (w_eff_flags),
    .i_cond  (bus.br_cond),
    .o_true  (w_cond)
  );

  // BA,a annuls even though taken; any other annulling branch only when untaken.
  assign w_annul = bus.br_annul & (~w_cond | (bus.br_cond == COND_BA));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_NORMAL;
      r_icc      <= 4'b0000;
      r_br_taken <= 1'b0;
      r_annul_ds <= 1'b0;
      r_dcti_err <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.cc_we) begin
        r_icc <= w_alu_icc;
      end
      case (r_state)
        ST_NORMAL: begin
          r_br_taken <= bus.br_valid & w_cond;
          r_annul_ds <= bus.br_valid & w_annul;
          r_dcti_err <= 1'b0;
          r_state    <= bus.br_valid ? ST_DSLOT : ST_NORMAL;
        end
        ST_DSLOT: begin
          // A branch in the delay slot is a DCTI couple: flagged, not resolved.
          r_br_taken <= 1'b0;
          r_annul_ds <= 1'b0;
          r_dcti_err <= bus.br_valid;
          r_state    <= ST_NORMAL;
        end
        default: begin
          r_br_taken <= 1'b0;
          r_annul_ds <= 1'b0;
          r_dcti_err <= 1'b0;
          r_state    <= ST_NORMAL;
        end
      endcase
    end
  end

  assign bus.icc      = r_icc;
  assign bus.cin      = r_icc[ICC_C];
  assign bus.br_taken = r_br_taken;
  assign bus.annul_ds = r_annul_ds;
  assign bus.dcti_err = r_dcti_err;

endmodule
